// File: rtl/mov_bus_pkg.sv
// rtl/mov_bus_pkg.sv - shared types and constants for the move bus arbiter
//
// Purpose: source count, select width, FSM state type and select type used by
//          mov_bus_arbiter and rr_pick16, plus a one-hot helper.
// Ports:   none (package).
package mov_bus_pkg;

  localparam int NUM_SRC = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } mov_state_t;

  typedef logic [SEL_W-1:0] mov_sel_t;

  function automatic logic [NUM_SRC-1:0] sel_onehot(input mov_sel_t s);
    return {{(NUM_SRC-1){1'b0}}, 1'b1} << s;
  endfunction

endpackage

// File: rtl/mov_bus_arbiter_rr_pick16.sv
// rtl/mov_bus_arbiter_rr_pick16.sv - rotating-priority find-first over 16 requests
//
// Purpose: returns the first set request searching from ptr+1 upward, wrapping
//          through 15 to 0, so index ptr itself is checked last.
// Ports:   req   [15:0] in  request vector
//          ptr   [3:0]  in  index of the most recent winner
//          found        out at least one request set
//          idx   [3:0]  out winning index (ptr when nothing is found)
module rr_pick16
  import mov_bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  mov_sel_t           ptr,
  output logic               found,
  output mov_sel_t           idx
);

  // Offsets 1..16; the 4-bit add wraps naturally, offset 16 lands on ptr.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!found && req[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mov_bus_arbiter.sv
// rtl/mov_bus_arbiter.sv - round-robin arbiter and beat sequencer for the 16-source move bus
//
// Purpose: grants one of 16 requesters the move bus, drives the mux select,
//          runs the valid/ready beat handshake and caps bursts at MAX_BURST.
// Ports:   clk              in  system clock, rising edge
//          rst_n            in  asynchronous active-low reset
//          req       [15:0] in  per-source request level
//          last      [15:0] in  per-source final-beat flag
//          bus_ready        in  destination accepts current beat
//          sel       [3:0]  out registered mux select
//          grant     [15:0] out registered one-hot grant, zero when idle
//          bus_valid        out current beat valid
//          beat_done        out beat accepted this cycle
//          busy             out transfer in progress
module mov_bus_arbiter
  import mov_bus_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] last,
  input  logic               bus_ready,
  output mov_sel_t           sel,
  output logic [NUM_SRC-1:0] grant,
  output logic               bus_valid,
  output logic               beat_done,
  output logic               busy
);

  mov_state_t         state, state_nxt;
  mov_sel_t           rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [NUM_SRC-1:0] pick_req;
  logic               pick_found;
  mov_sel_t           pick_idx;
  logic               withdraw, end_last, end_cap, burst_end, load_grant;

  rr_pick16 u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    withdraw  = (state == XFER) && !req[sel];
    end_last  = beat_done && last[sel];
    end_cap   = beat_done && (beat_cnt == CNT_W'(MAX_BURST - 1));
    burst_end = withdraw || end_last || end_cap;

    // A cap-cut source stays eligible; rr_ptr == sel already ranks it last.
    pick_req = req;
    if ((state == XFER) && (withdraw || end_last)) begin
      pick_req[sel] = 1'b0;
    end

    load_grant = pick_found && ((state == IDLE) || burst_end);

    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = XFER;
      XFER:    if (burst_end && !pick_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == XFER);
    bus_valid = busy && req[sel];
    beat_done = bus_valid && bus_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      grant    <= '0;
      rr_ptr   <= '1;
      beat_cnt <= '0;
    end else if (load_grant) begin
      sel      <= pick_idx;
      grant    <= sel_onehot(pick_idx);
      rr_ptr   <= pick_idx;
      beat_cnt <= '0;
    end else if ((state == XFER) && burst_end) begin
      // No one else is waiting: drop the grant but leave sel parked.
      grant    <= '0;
    end else if (beat_done) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mov_bus_arbiter.sv
// tb/tb_mov_bus_arbiter.sv - self-checking bench for mov_bus_arbiter
module tb_mov_bus_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, last, grant;
  logic        bus_ready;
  logic [3:0]  sel;
  logic        bus_valid, beat_done, busy;

  int passed = 0;
  int total  = 0;

  // Reference model: owner index (-1 idle), last winner, parked select, beats taken.
  int m_owner, m_ptr, m_sel, m_beats;
  logic [22:0] exp_vec;
  wire  [22:0] obs_vec = {grant, sel, bus_valid, beat_done, busy};

  mov_bus_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .bus_ready (bus_ready),
    .sel       (sel),
    .grant     (grant),
    .bus_valid (bus_valid),
    .beat_done (beat_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 1; k <= 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 15; m_sel = 0; m_beats = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w; m_ptr = w; m_sel = w; m_beats = 0;
  endtask

  task automatic model_comb();
    logic [15:0] g;
    logic        v;
    g = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0;
    v = (m_owner >= 0) ? req[m_owner] : 1'b0;
    exp_vec = {g, 4'(m_sel), v, v & bus_ready, (m_owner >= 0)};
  endtask

  task automatic model_update();
    logic [15:0] masked;
    logic        ended;
    int          w;
    if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      ended  = 1'b0;
      masked = req;
      if (!req[m_owner]) begin
        ended = 1'b1;
      end else if (bus_ready) begin
        m_beats++;
        if (last[m_owner]) begin
          ended = 1'b1;
          masked[m_owner] = 1'b0;
        end else if (m_beats == MAX_BURST) begin
          ended = 1'b1;
        end
      end
      if (ended) begin
        w = pick(masked, m_ptr);
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end
    end
  endtask

  task automatic drive(input logic [15:0] r, input logic [15:0] l, input logic rdy);
    @(negedge clk);
    req = r; last = l; bus_ready = rdy;
    #1;
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0;
    @(negedge clk);
    total++;
    if (obs_vec !== 23'h0) $display("FAIL reset_state: got %h expected %h", obs_vec, 23'h0);
    else passed++;
    rst_n = 1'b1;
    model_reset();
    drive(16'h0001, 16'h0001, 1'b1);
    total++;
    if (obs_vec !== exp_vec) $display("FAIL reset_idle: got %h expected %h", obs_vec, exp_vec);
    else passed++;
    advance();
    drive(16'h0001, 16'h0001, 1'b1);
    total++;
    if (grant !== 16'h0001 || sel !== 4'd0 || bus_valid !== 1'b1 || beat_done !== 1'b1)
      $display("FAIL first_grant: got grant=%h sel=%0d v=%b d=%b expected grant=0001 sel=0 v=1 d=1",
               grant, sel, bus_valid, beat_done);
    else passed++;
    advance();
    drive(16'h0000, 16'h0000, 1'b1);
    total++;
    if (grant !== 16'h0 || busy !== 1'b0 || beat_done !== 1'b0)
      $display("FAIL back_to_idle: got grant=%h busy=%b d=%b expected 0000/0/0", grant, busy, beat_done);
    else passed++;
    advance();
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 4, 15, 0, 4};
    apply_reset();
    drive(16'h8011, 16'hFFFF, 1'b1);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(16'h8011, 16'hFFFF, 1'b1);
      total++;
      if (sel !== 4'(seq[i]) || busy !== 1'b1 || obs_vec !== exp_vec)
        $display("FAIL round_robin[%0d]: got sel=%0d vec=%h expected sel=%0d vec=%h",
                 i, sel, obs_vec, seq[i], exp_vec);
      else passed++;
      advance();
    end
  endtask

  task automatic test_burst_cap();
    int seq[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    apply_reset();
    drive(16'h0006, 16'h0000, 1'b1);
    advance();
    for (int i = 0; i < 9; i++) begin
      drive(16'h0006, 16'h0000, 1'b1);
      total++;
      if (sel !== 4'(seq[i]) || beat_done !== 1'b1 || obs_vec !== exp_vec)
        $display("FAIL burst_cap[%0d]: got sel=%0d vec=%h expected sel=%0d vec=%h",
                 i, sel, obs_vec, seq[i], exp_vec);
      else passed++;
      advance();
    end
  endtask

  task automatic test_backpressure();
    int dones;
    apply_reset();
    drive(16'h0008, 16'h0008, 1'b0);
    advance();
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      drive(16'h0008, 16'h0008, 1'b0);
      total++;
      if (sel !== 4'd3 || grant !== 16'h0008 || bus_valid !== 1'b1 || beat_done !== 1'b0)
        $display("FAIL stall[%0d]: got sel=%0d grant=%h v=%b d=%b expected 3/0008/1/0",
                 i, sel, grant, bus_valid, beat_done);
      else passed++;
      advance();
    end
    drive(16'h0008, 16'h0008, 1'b1);
    if (beat_done === 1'b1) dones++;
    advance();
    drive(16'h0000, 16'h0000, 1'b1);
    if (beat_done === 1'b1) dones++;
    total++;
    if (dones !== 1 || busy !== 1'b0)
      $display("FAIL stall_release: got beats=%0d busy=%b expected beats=1 busy=0", dones, busy);
    else passed++;
    advance();
  endtask

  task automatic test_withdraw();
    apply_reset();
    drive(16'h0020, 16'h0000, 1'b0);
    advance();
    drive(16'h0020, 16'h0000, 1'b0);
    total++;
    if (grant !== 16'h0020 || sel !== 4'd5)
      $display("FAIL withdraw_grant: got grant=%h sel=%0d expected 0020/5", grant, sel);
    else passed++;
    advance();
    drive(16'h0100, 16'h0000, 1'b1);
    total++;
    if (bus_valid !== 1'b0 || beat_done !== 1'b0 || obs_vec !== exp_vec)
      $display("FAIL withdraw_nobeat: got v=%b d=%b vec=%h expected v=0 d=0 vec=%h",
               bus_valid, beat_done, obs_vec, exp_vec);
    else passed++;
    advance();
    drive(16'h0100, 16'h0000, 1'b0);
    total++;
    if (grant !== 16'h0100 || sel !== 4'd8)
      $display("FAIL withdraw_next: got grant=%h sel=%0d expected 0100/8", grant, sel);
    else passed++;
    advance();
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(16'hFFFF, 16'h0000, 1'b0);
    advance();
    drive(16'hFFFF, 16'h0000, 1'b0);
    advance();
    drive(16'hFFFF, 16'h0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (grant !== 16'h0 || bus_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset: got grant=%h v=%b busy=%b expected 0000/0/0", grant, bus_valid, busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; req = '0;
    model_reset();
    drive(16'hFFFF, 16'h0000, 1'b1);
    advance();
    drive(16'hFFFF, 16'h0000, 1'b1);
    total++;
    if (grant !== 16'h0001 || sel !== 4'd0)
      $display("FAIL post_reset_grant: got grant=%h sel=%0d expected 0001/0", grant, sel);
    else passed++;
    advance();
  endtask

  task automatic test_random();
    logic [15:0] r;
    apply_reset();
    r = 16'(($urandom));
    for (int i = 0; i < 400; i++) begin
      r = r ^ 16'($urandom & $urandom & $urandom);
      drive(r, 16'($urandom & $urandom), ($urandom % 4) != 0);
      total++;
      if (obs_vec !== exp_vec)
        $display("FAIL random[%0d]: got %h expected %h (req=%h last=%h rdy=%b)",
                 i, obs_vec, exp_vec, req, last, bus_ready);
      else passed++;
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
